// File: rtl/sseg_scan_ctrl.sv
// Multiplexed seven-segment scanner with hex or decimal (double-dabble) view.
// Adds sign, leading-zero blanking, per-digit dp and overflow dashes.
module sseg_scan_ctrl #(
  parameter int DIGITS   = 4,
  parameter int DATA_W   = 16,
  parameter int SCAN_DIV = 100000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] data,
  input  logic              hex_dec,
  input  logic              sign,
  input  logic              blank_lz,
  input  logic [DIGITS-1:0] dp_mask,
  input  logic              load,
  output logic              busy,
  output logic              conv_done,
  output logic [6:0]        seg,
  output logic [DIGITS-1:0] an,
  output logic              dp
);

  localparam int BCD_N = (DATA_W + 3) / 3;
  localparam int BW    = 4 * BCD_N;
  localparam int MW    = DATA_W + 1;
  localparam int DDW   = BW + MW;
  localparam int HW    = (4 * DIGITS > DATA_W) ? 4 * DIGITS : DATA_W;
  localparam int DW    = (4 * DIGITS > BW) ? 4 * DIGITS : BW;
  localparam int PW    = $clog2(SCAN_DIV);
  localparam int IW    = $clog2(DIGITS);
  localparam int CW    = $clog2(MW + 1);

  localparam logic [6:0] DASH  = 7'h3F;
  localparam logic [6:0] BLANK = 7'h7F;

  function automatic logic [6:0] glyph(input logic [3:0] v);
    logic [6:0] g;
    case (v)
      4'h0: g = 7'h3F;
      4'h1: g = 7'h06;
      4'h2: g = 7'h5B;
      4'h3: g = 7'h4F;
      4'h4: g = 7'h66;
      4'h5: g = 7'h6D;
      4'h6: g = 7'h7D;
      4'h7: g = 7'h07;
      4'h8: g = 7'h7F;
      4'h9: g = 7'h6F;
      4'hA: g = 7'h77;
      4'hB: g = 7'h7C;
      4'hC: g = 7'h39;
      4'hD: g = 7'h5E;
      4'hE: g = 7'h79;
      default: g = 7'h71;
    endcase
    return ~g;
  endfunction

  logic [PW-1:0]            presc;
  logic [IW-1:0]            idx;
  logic                     valid;
  logic [DIGITS-1:0][6:0]   disp_seg;
  logic [DIGITS-1:0]        disp_dp;

  logic [DDW-1:0]           dd;
  logic [DDW-1:0]           dd_adj;
  logic [DDW-1:0]           dd_nxt;
  logic [CW-1:0]            cnt;
  logic                     neg_q;
  logic                     blz_q;
  logic [DIGITS-1:0]        dpm_q;
  logic                     last;
  logic                     neg_in;
  logic [MW-1:0]            mag_in;

  logic [HW-1:0]            hex_pad;
  logic [DW-1:0]            dec_pad;
  logic                     ovf;
  logic                     lead;
  logic [DIGITS-1:0][6:0]   hex_seg;
  logic [DIGITS-1:0][6:0]   dec_seg;
  logic [DIGITS-1:0]        dec_dp;

  // BCD digits sit above the binary bits; one add-3 then shift per clock
  always_comb begin
    dd_adj = dd;
    for (int n = 0; n < BCD_N; n++) begin
      if (dd[MW+4*n +: 4] >= 4'd5)
        dd_adj[MW+4*n +: 4] = dd[MW+4*n +: 4] + 4'd3;
    end
    dd_nxt = dd_adj << 1;
    last   = busy && (cnt == CW'(MW - 1));
    neg_in = sign && data[DATA_W-1];
    mag_in = neg_in ? -{data[DATA_W-1], data}
                    : {1'b0, data};
  end

  always_comb begin
    hex_pad = HW'(data);
    hex_seg = '0;
    for (int i = 0; i < DIGITS; i++)
      hex_seg[i] = glyph(hex_pad[4*i +: 4]);

    dec_pad = DW'(dd_nxt[DDW-1 -: BW]);
    ovf     = 1'b0;
    for (int n = 0; n < DW / 4; n++) begin
      if (dec_pad[4*n +: 4] != 4'd0 &&
          (n >= DIGITS || (neg_q && n == DIGITS - 1)))
        ovf = 1'b1;
    end

    lead    = 1'b1;
    dec_seg = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      if (neg_q && i == DIGITS - 1) begin
        dec_seg[i] = DASH;
      end else begin
        lead = lead && (dec_pad[4*i +: 4] == 4'd0);
        dec_seg[i] = (blz_q && lead && i != 0) ? BLANK
                   : glyph(dec_pad[4*i +: 4]);
      end
    end
    dec_dp = ~dpm_q;

    if (ovf) begin
      dec_seg = {DIGITS{DASH}};
      dec_dp  = '1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy      <= 1'b0;
      conv_done <= 1'b0;
      valid     <= 1'b0;
      disp_seg  <= '0;
      disp_dp   <= '0;
      dd        <= '0;
      cnt       <= '0;
      neg_q     <= 1'b0;
      blz_q     <= 1'b0;
      dpm_q     <= '0;
    end else begin
      conv_done <= 1'b0;
      if (busy) begin
        dd  <= dd_nxt;
        cnt <= cnt + CW'(1);
        if (last) begin
          busy      <= 1'b0;
          disp_seg  <= dec_seg;
          disp_dp   <= dec_dp;
          conv_done <= 1'b1;
          valid     <= 1'b1;
        end
      end else if (load) begin
        if (hex_dec) begin
          busy  <= 1'b1;
          cnt   <= '0;
          dd    <= {{BW{1'b0}}, mag_in};
          neg_q <= neg_in;
          blz_q <= blank_lz;
          dpm_q <= dp_mask;
        end else begin
          disp_seg  <= hex_seg;
          disp_dp   <= ~dp_mask;
          conv_done <= 1'b1;
          valid     <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
      idx   <= '0;
      seg   <= BLANK;
      an    <= '1;
      dp    <= 1'b1;
    end else begin
      if (presc == PW'(SCAN_DIV - 1)) begin
        presc <= '0;
        idx   <= (idx == IW'(DIGITS - 1)) ? '0
               : idx + IW'(1);
      end else begin
        presc <= presc + PW'(1);
      end
      if (valid) begin
        seg <= disp_seg[idx];
        an  <= ~(DIGITS'(1) << idx);
        dp  <= disp_dp[idx];
      end else begin
        seg <= BLANK;
        an  <= '1;
        dp  <= 1'b1;
      end
    end
  end

endmodule
